// File: rtl/spi_tx_queue_pkg.sv
// Shared types and defaults for the SPI transmit queue.
package spi_tx_queue_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/spi_tx_queue_if.sv
// Upstream register-decode side and downstream SPI engine side of the queue.
interface spi_tx_queue_if
    import spi_tx_queue_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             push_width_16;
    logic             flush;
    logic             clear_overflow;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             busy;
    logic             spi_start;
    logic [WIDTH-1:0] spi_data_tx;
    logic             spi_width_16;
    logic             spi_busy;

    modport slave (
        input  push, push_data, push_width_16, flush, clear_overflow, spi_busy,
        output count, full, empty, overflow, busy, spi_start, spi_data_tx, spi_width_16
    );

    modport master (
        output push, push_data, push_width_16, flush, clear_overflow, spi_busy,
        input  count, full, empty, overflow, busy, spi_start, spi_data_tx, spi_width_16
    );

endinterface

// File: rtl/spi_tx_queue_sync_fifo.sv
// Single-clock FIFO with a separate count register and a flush that drops all queued entries.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 17,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic [CW-1:0]               count_q, count_n;
    logic                        full_q, empty_q;
    logic                        wr_ok, rd_ok;

    // Acceptance uses the pre-edge flags, so a push while full is lost even if a pop frees a slot.
    assign wr_ok = wr_en && !full_q && !flush;
    assign rd_ok = rd_en && !empty_q && !flush;

    always_comb begin
        count_n = count_q;
        if (wr_ok && !rd_ok)
            count_n = count_q + 1'b1;
        else if (rd_ok && !wr_ok)
            count_n = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else if (flush) begin
            rd_ptr  <= wr_ptr;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_n;
            full_q  <= (count_n == CW'(DEPTH));
            empty_q <= (count_n == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign count   = count_q;
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/spi_tx_queue.sv
// Buffered SPI transmit front-end: queues CPU words and issues one start/busy handshake per word.
module spi_tx_queue
    import spi_tx_queue_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic           raw_clk,
    input  logic           reset,
    spi_tx_queue_if.slave  bus
);

    state_e           state_q, state_d;
    logic             fifo_pop;
    logic [WIDTH:0]   fifo_rd;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full, fifo_empty;
    logic             start_q, width_q, overflow_q;
    logic [WIDTH-1:0] data_q;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH + 1)
    ) u_fifo (
        .clk     (raw_clk),
        .rst     (reset),
        .wr_en   (bus.push),
        .wr_data ({bus.push_width_16, bus.push_data}),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd),
        .flush   (bus.flush),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge raw_clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty && !bus.flush) state_d = ST_START;
            ST_START: if (bus.spi_busy)              state_d = ST_WAIT;
            ST_WAIT:  if (!bus.spi_busy)             state_d = ST_IDLE;
            default:                                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop = (state_q == ST_IDLE) && !fifo_empty && !bus.flush;
    end

    // The popped word lives in data_q/width_q, so a flush cannot disturb an in-flight transfer.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            start_q    <= 1'b0;
            data_q     <= '0;
            width_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            start_q <= (state_d == ST_START);
            if (fifo_pop) {width_q, data_q} <= fifo_rd;
            if (bus.clear_overflow)
                overflow_q <= 1'b0;
            else if (bus.push && fifo_full)
                overflow_q <= 1'b1;
        end
    end

    assign bus.count        = fifo_count;
    assign bus.full         = fifo_full;
    assign bus.empty        = fifo_empty;
    assign bus.overflow     = overflow_q;
    assign bus.busy         = (state_q != ST_IDLE) || !fifo_empty;
    assign bus.spi_start    = start_q;
    assign bus.spi_data_tx  = data_q;
    assign bus.spi_width_16 = width_q;

endmodule

// File: tb/tb_spi_tx_queue.sv
// Scoreboard bench: queued words are expected at the SPI engine model in push order.
module tb_spi_tx_queue;

    logic raw_clk;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   eng_len = 10;
    int   eng_cnt = 0;
    bit   eng_hold = 0;
    logic [16:0] exp_q[$];

    spi_tx_queue_if #(.DEPTH(8), .WIDTH(16)) bus ();

    spi_tx_queue #(.DEPTH(8), .WIDTH(16)) dut (
        .raw_clk (raw_clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial raw_clk = 1'b0;
    always #5 raw_clk = ~raw_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [15:0] d, input logic w, input bit expect_tx);
        bus.push          = 1'b1;
        bus.push_data     = d;
        bus.push_width_16 = w;
        if (expect_tx) exp_q.push_back({w, d});
        @(posedge raw_clk); #1;
        bus.push = 1'b0;
    endtask

    task automatic wait_busy_low(input int max);
        int n = 0;
        while (bus.spi_busy && n < max) begin
            @(negedge raw_clk); #1;
            n++;
        end
        chk("engine_busy_timeout", bus.spi_busy, 0);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((bus.busy || bus.spi_busy) && n < max) begin
            @(posedge raw_clk); #1;
            n++;
        end
        chk("drain_busy", bus.busy, 0);
        chk("drain_count", bus.count, 0);
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // SPI engine model: accepts a start, compares the word, then stays busy for eng_len cycles.
    initial begin
        logic [16:0] e;
        bus.spi_busy = 1'b0;
        forever begin
            @(negedge raw_clk);
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) bus.spi_busy = 1'b0;
            end else if (bus.spi_start && !eng_hold) begin
                if (exp_q.size() == 0) begin
                    chk("tx_unexpected_word", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_data", bus.spi_data_tx, e[15:0]);
                    chk("tx_width_16", bus.spi_width_16, e[16]);
                end
                bus.spi_busy = 1'b1;
                eng_cnt      = eng_len;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset              = 1'b1;
        bus.push           = 1'b0;
        bus.push_data      = '0;
        bus.push_width_16  = 1'b0;
        bus.flush          = 1'b0;
        bus.clear_overflow = 1'b0;
        repeat (3) @(posedge raw_clk);
        #1 reset = 1'b0;

        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_start", bus.spi_start, 0);
        chk("rst_data", bus.spi_data_tx, 0);
        chk("rst_w16", bus.spi_width_16, 0);

        // Single word: start two cycles after the push, drops one cycle after engine busy.
        eng_len = 10;
        push_word(16'h00A5, 1'b0, 1'b1);
        chk("t1_count", bus.count, 1);
        chk("t1_empty", bus.empty, 0);
        chk("t1_start_early", bus.spi_start, 0);
        @(posedge raw_clk); #1;
        chk("t1_start", bus.spi_start, 1);
        chk("t1_data", bus.spi_data_tx, 16'h00A5);
        chk("t1_count_pop", bus.count, 0);
        @(posedge raw_clk); #1;
        chk("t1_engine_busy", bus.spi_busy, 1);
        chk("t1_start_drop", bus.spi_start, 0);
        wait_busy_low(100);
        chk("t1_busy_wait", bus.busy, 1);
        @(posedge raw_clk); #1;
        chk("t1_busy_fall", bus.busy, 0);
        chk("t1_data_hold", bus.spi_data_tx, 16'h00A5);

        // Fill while a long transfer is in flight, then overflow.
        eng_len = 30;
        push_word(16'h0FFF, 1'b0, 1'b1);
        @(posedge raw_clk); @(posedge raw_clk); #1;
        for (int i = 0; i < 8; i++) push_word(16'h1000 + 16'(i), 1'b0, 1'b1);
        chk("t2_full", bus.full, 1);
        chk("t2_count", bus.count, 8);
        chk("t2_ovf_pre", bus.overflow, 0);
        push_word(16'hDEAD, 1'b0, 1'b0);
        chk("t2_overflow", bus.overflow, 1);
        chk("t2_count_ovf", bus.count, 8);
        bus.clear_overflow = 1'b1;
        @(posedge raw_clk); #1;
        bus.clear_overflow = 1'b0;
        chk("t2_ovf_clear", bus.overflow, 0);

        // Rejected push on the same edge as the IDLE pop.
        wait_busy_low(200);
        @(posedge raw_clk); #1;
        chk("t3_count_idle", bus.count, 8);
        push_word(16'hBEEF, 1'b0, 1'b0);
        chk("t3_count_pop", bus.count, 7);
        chk("t3_overflow", bus.overflow, 1);
        chk("t3_start", bus.spi_start, 1);
        push_word(16'h1008, 1'b1, 1'b1);
        chk("t3_refill", bus.count, 8);
        bus.clear_overflow = 1'b1;
        push_word(16'h0BAD, 1'b0, 1'b0);
        bus.clear_overflow = 1'b0;
        chk("t3_clear_prio", bus.overflow, 0);
        chk("t3_count_keep", bus.count, 8);
        eng_len = 3;
        wait_idle(2000);

        // Flush while the first of three words is in WAIT.
        eng_len = 10;
        push_word(16'h2001, 1'b0, 1'b1);
        push_word(16'h2002, 1'b0, 1'b1);
        push_word(16'h2003, 1'b0, 1'b1);
        chk("t4_count", bus.count, 2);
        chk("t4_in_wait", bus.spi_busy, 1);
        exp_q.delete();
        bus.flush = 1'b1;
        @(posedge raw_clk); #1;
        bus.flush = 1'b0;
        chk("t4_flush_count", bus.count, 0);
        chk("t4_flush_empty", bus.empty, 1);
        chk("t4_busy_inflight", bus.busy, 1);
        chk("t4_data_hold", bus.spi_data_tx, 16'h2001);
        wait_idle(200);

        // Mixed widths travel with their own word.
        eng_len = 4;
        push_word(16'h1234, 1'b1, 1'b1);
        push_word(16'h0056, 1'b0, 1'b1);
        wait_idle(200);

        // Reset in START with four words queued.
        eng_hold = 1;
        for (int i = 0; i < 5; i++) push_word(16'h3000 + 16'(i), 1'b1, 1'b0);
        chk("t6_count", bus.count, 4);
        chk("t6_start", bus.spi_start, 1);
        reset = 1'b1;
        @(posedge raw_clk); #1;
        reset = 1'b0;
        chk("t6_rst_start", bus.spi_start, 0);
        chk("t6_rst_count", bus.count, 0);
        chk("t6_rst_empty", bus.empty, 1);
        chk("t6_rst_busy", bus.busy, 0);
        eng_hold = 0;
        push_word(16'h0077, 1'b0, 1'b1);
        @(posedge raw_clk); #1;
        chk("t6_post_start", bus.spi_start, 1);
        chk("t6_post_data", bus.spi_data_tx, 16'h0077);
        wait_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
